// File: rtl/icache_pkg.sv
// Shared constants for the icache: bus widths, FSM state encodings and default geometry.
package icache_pkg;

  localparam int unsigned ADDR_WID     = 32;
  localparam int unsigned DATA_WID     = 32;
  localparam int unsigned DefLineWords = 4;
  localparam int unsigned DefNumLines  = 16;

  // Highest PC bit that takes part in the tag
  localparam int unsigned TagTopBit    = 17;
  localparam logic [1:0]  BypassSel    = 2'b11;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRefill = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

endpackage

// File: rtl/icache_mem.sv
// Valid, tag and data arrays of the direct-mapped icache.
// Synchronous writes, combinational read by index; valid bits clear on reset.
module icache_mem
  import icache_pkg::*;
#(
  parameter int unsigned OffW = 2,
  parameter int unsigned IdxW = 4,
  parameter int unsigned TagW = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inv_en_i,
  input  logic [IdxW-1:0]     inv_idx_i,
  input  logic                wr_en_i,
  input  logic [IdxW-1:0]     wr_idx_i,
  input  logic [OffW-1:0]     wr_off_i,
  input  logic [DATA_WID-1:0] wr_data_i,
  input  logic                inst_en_i,
  input  logic [TagW-1:0]     inst_tag_i,
  input  logic [IdxW-1:0]     rd_idx_i,
  input  logic [OffW-1:0]     rd_off_i,
  output logic [DATA_WID-1:0] rd_data_o,
  output logic [TagW-1:0]     rd_tag_o,
  output logic                rd_valid_o
);

  logic [2**IdxW-1:0]   valid_q;
  logic [TagW-1:0]      tag_q  [2**IdxW];
  logic [DATA_WID-1:0]  data_q [2**(IdxW+OffW)];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (inv_en_i)  valid_q[inv_idx_i] <= 1'b0;
      if (inst_en_i) valid_q[wr_idx_i]  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i)   data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
    if (inst_en_i) tag_q[wr_idx_i]              <= inst_tag_i;
  end

  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with word-serial refill from memctrl.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counter ports.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DefLineWords,
  parameter int unsigned NUM_LINES  = DefNumLines
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rollback,
  input  logic                if_req,
  input  logic [ADDR_WID-1:0] if_pc,
  output logic                if_ready,
  output logic                inst_valid,
  output logic [DATA_WID-1:0] inst_out,
  output logic [ADDR_WID-1:0] inst_pc,
  output logic                mc_req,
  output logic [ADDR_WID-1:0] mc_addr,
  input  logic                mc_done,
  input  logic [DATA_WID-1:0] mc_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int unsigned     OffW     = $clog2(LINE_WORDS);
  localparam int unsigned     IdxW     = $clog2(NUM_LINES);
  localparam int unsigned     TagW     = TagTopBit - 1 - OffW - IdxW;
  localparam logic [OffW-1:0] LastWord = OffW'(LINE_WORDS - 1);

  logic [1:0]          state_q, state_d;
  logic [ADDR_WID-1:2] pc_q, pc_d;
  logic [OffW-1:0]     k_q, k_d;
  logic                byp_q, byp_d;
  logic                kill_q, kill_d;
  logic                hit_q, hit_d;
  logic [DATA_WID-1:0] out_q, out_d;
  logic [ADDR_WID-1:0] opc_q, opc_d;

  logic [OffW-1:0]     req_off;
  logic [IdxW-1:0]     req_idx;
  logic [TagW-1:0]     req_tag;
  logic                req_byp, hit, accept, last_word, fill_done;
  logic [DATA_WID-1:0] rd_data;
  logic [TagW-1:0]     rd_tag;
  logic                rd_valid;

  assign req_off   = if_pc[2 +: OffW];
  assign req_idx   = if_pc[2+OffW +: IdxW];
  assign req_tag   = if_pc[2+OffW+IdxW +: TagW];
  assign req_byp   = (if_pc[17:16] == BypassSel);
  assign hit       = rd_valid & (rd_tag == req_tag) & ~req_byp;
  assign if_ready  = rst_in & rdy_in & ~rollback & (state_q == StIdle);
  assign accept    = if_ready & if_req;
  assign last_word = byp_q | (k_q == LastWord);
  // A memctrl word is only consumed when the block is live and actually refilling
  assign fill_done = rst_in & rdy_in & mc_done & (state_q == StRefill);

  icache_mem #(
    .OffW (OffW),
    .IdxW (IdxW),
    .TagW (TagW)
  ) u_mem (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .inv_en_i   (accept & ~hit & ~req_byp),
    .inv_idx_i  (req_idx),
    .wr_en_i    (fill_done & ~byp_q),
    .wr_idx_i   (pc_q[2+OffW +: IdxW]),
    .wr_off_i   (k_q),
    .wr_data_i  (mc_data),
    .inst_en_i  (fill_done & ~byp_q & last_word),
    .inst_tag_i (pc_q[2+OffW+IdxW +: TagW]),
    .rd_idx_i   (req_idx),
    .rd_off_i   (req_off),
    .rd_data_o  (rd_data),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    k_d     = k_q;
    byp_d   = byp_q;
    kill_d  = kill_q;
    hit_d   = 1'b0;
    out_d   = out_q;
    opc_d   = opc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opc_d = if_pc;
          if (hit) begin
            hit_d = 1'b1;
            out_d = rd_data;
          end else begin
            state_d = StRefill;
            pc_d    = if_pc[ADDR_WID-1:2];
            k_d     = '0;
            byp_d   = req_byp;
            kill_d  = 1'b0;
          end
        end
      end
      StRefill: begin
        if (rollback) kill_d = 1'b1;
        if (fill_done) begin
          if (byp_q || (k_q == pc_q[2 +: OffW])) out_d = mc_data;
          k_d = k_q + 1'b1;
          // A flushed refill still installs the line but skips the response
          if (last_word) state_d = (kill_q | rollback) ? StIdle : StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
      pc_q    <= '0;
      k_q     <= '0;
      byp_q   <= 1'b0;
      kill_q  <= 1'b0;
      hit_q   <= 1'b0;
      out_q   <= '0;
      opc_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
      byp_q   <= byp_d;
      kill_q  <= kill_d;
      hit_q   <= hit_d;
      out_q   <= out_d;
      opc_q   <= opc_d;
    end
  end

  assign inst_valid = rst_in & ~rollback & (hit_q | (state_q == StResp));
  assign inst_out   = rst_in ? out_q : '0;
  assign inst_pc    = rst_in ? opc_q : '0;
  assign mc_req     = rst_in & (state_q == StRefill);
  assign mc_addr    = !rst_in ? '0 :
                      byp_q   ? {pc_q, 2'b00} :
                                {pc_q[ADDR_WID-1:2+OffW], k_q, 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: memctrl responder, cycle-level reference model of the
// fetch protocol, and directed scenarios with hand-computed expectations.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, rollback, if_req, mc_done;
  logic [31:0] if_pc, mc_data;
  logic        if_ready, inst_valid, mc_req;
  logic [31:0] inst_out, inst_pc, mc_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] addr_log[$];

  always #5 clk = ~clk;

  icache u_dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rollback   (rollback),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .mc_req     (mc_req),
    .mc_addr    (mc_addr),
    .mc_done    (mc_done),
    .mc_data    (mc_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic int m_index(input logic [31:0] pc);
    return int'(pc[7:4]);
  endfunction

  function automatic logic [9:0] m_tag_of(input logic [31:0] pc);
    return pc[17:8];
  endfunction

  function automatic bit m_is_byp(input logic [31:0] pc);
    return pc[17:16] == 2'b11;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memctrl: returns one word every other cycle while mc_req is high.
  initial begin
    logic [31:0] last_addr;
    last_addr = '0;
    mc_done = 1'b0;
    mc_data = '0;
    forever begin
      @(posedge clk);
      if (mc_done && rdy_in && rst_in) begin
        done_cnt++;
        addr_log.push_back(last_addr);
      end
      #1;
      if (mc_req && !mc_done) begin
        mc_done   = 1'b1;
        last_addr = mc_addr;
        mc_data   = memword(mc_addr);
      end else begin
        mc_done = 1'b0;
        mc_data = 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: cache contents by index/tag, refill progress and pending responses.
  bit          m_valid[16];
  logic [9:0]  m_tag[16];
  int          words_left = 0;
  bit          killed = 0, hit_pend = 0, resp_pend = 0, m_byp = 0;
  logic [31:0] r_pc = '0, r_data = '0;
  logic [31:0] exp_addr[$];

  initial begin
    bit busy, exp_v, nh, nr;
    forever begin
      @(negedge clk);
      busy  = (words_left > 0) || resp_pend;
      exp_v = rst_in && !rollback && (hit_pend || resp_pend);
      chk("inst_valid", inst_valid, exp_v);
      if (exp_v) begin
        chk("inst_out", inst_out, r_data);
        chk("inst_pc", inst_pc, r_pc);
      end
      chk("if_ready", if_ready, rst_in && rdy_in && !rollback && !busy);
      chk("mc_req", mc_req, rst_in && (words_left > 0));
      if (!rst_in) begin
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_mc_addr", mc_addr, 32'h0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        words_left = 0;
        hit_pend   = 1'b0;
        resp_pend  = 1'b0;
        exp_addr.delete();
      end else if (rdy_in) begin
        nh = 1'b0;
        nr = 1'b0;
        if (words_left > 0) begin
          if (rollback) killed = 1'b1;
          if (mc_done) begin
            chk("mc_addr", mc_addr, exp_addr.pop_front());
            words_left--;
            if (words_left == 0) begin
              if (!m_byp) begin
                m_valid[m_index(r_pc)] = 1'b1;
                m_tag[m_index(r_pc)]   = m_tag_of(r_pc);
              end
              nr = !killed;
            end
          end
        end else if (!resp_pend && if_req && !rollback) begin
          r_pc   = if_pc;
          r_data = memword({if_pc[31:2], 2'b00});
          if (!m_is_byp(if_pc) && m_valid[m_index(if_pc)] &&
              m_tag[m_index(if_pc)] == m_tag_of(if_pc)) begin
            nh = 1'b1;
          end else begin
            m_byp  = m_is_byp(if_pc);
            killed = 1'b0;
            if (m_byp) begin
              words_left = 1;
              exp_addr.push_back({if_pc[31:2], 2'b00});
            end else begin
              m_valid[m_index(if_pc)] = 1'b0;
              words_left = 4;
              for (int k = 0; k < 4; k++) exp_addr.push_back({if_pc[31:4], 4'h0} + 32'(4 * k));
            end
          end
        end
        hit_pend  = nh;
        resp_pend = nr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    if_req = 1'b1;
    if_pc  = pc;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (if_ready) ok = 1'b1;
    end
    chk("fetch_accept", ok, 1'b1);
    step();
    if_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic [31:0] d, output logic [31:0] p);
    int n;
    n   = 0;
    lat = -1;
    d   = 'x;
    p   = 'x;
    while (lat < 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (inst_valid) begin
        lat = n;
        d   = inst_out;
        p   = inst_pc;
      end
    end
    chk("resp_seen", lat > 0, 1'b1);
    step();
  endtask

  task automatic wait_dones(input int n);
    int i;
    i = 0;
    while (done_cnt < n && i < 200) begin
      step();
      i++;
    end
    chk("dones_reached", done_cnt >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, nv;
    logic [31:0] d, p;
    rst_in = 1'b0; rdy_in = 1'b1; rollback = 1'b0; if_req = 1'b0; if_pc = '0;
    repeat (3) step();
    rst_in = 1'b1;
    step();

    // Cold miss at 0x100: four ordered word reads, first word returned
    done_cnt = 0; addr_log.delete();
    fetch(32'h100);
    wait_valid(lat, d, p);
    chk("cold_data", d, 32'hC0DE_0100);
    chk("cold_pc", p, 32'h100);
    chk("cold_words", done_cnt, 4);
    for (int i = 0; i < 4; i++) chk("cold_addr", addr_log[i], 32'h100 + 32'(4 * i));

    // Hit on the same line, third word
    done_cnt = 0;
    fetch(32'h108);
    wait_valid(lat, d, p);
    chk("hit_latency", lat, 1);
    chk("hit_data", d, 32'hC0DE_0108);
    chk("hit_no_mem", done_cnt, 0);

    // Conflict on index 0
    done_cnt = 0;
    fetch(32'h200);
    wait_valid(lat, d, p);
    chk("conf_words", done_cnt, 4);
    chk("conf_data", d, 32'hC0DE_0200);
    done_cnt = 0;
    fetch(32'h100);
    wait_valid(lat, d, p);
    chk("conf_remiss", done_cnt, 4);

    // Rollback mid-refill: no response, line still installed
    done_cnt = 0;
    fetch(32'h40);
    wait_dones(2);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (inst_valid) nv++;
    end
    step();
    chk("rb_no_valid", nv, 0);
    chk("rb_words", done_cnt, 4);
    fetch(32'h40);
    wait_valid(lat, d, p);
    chk("rb_hit_latency", lat, 1);
    chk("rb_hit_data", d, 32'hC0DE_0040);

    // Stall mid-refill: address and progress hold
    done_cnt = 0;
    fetch(32'h80);
    wait_dones(1);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr", mc_addr, 32'h84);
      step();
    end
    chk("stall_words", done_cnt, 1);
    rdy_in = 1'b1;
    wait_valid(lat, d, p);
    chk("stall_data", d, 32'hC0DE_0080);
    chk("stall_total", done_cnt, 4);

    // Reset mid-refill: outputs zero, line left invalid
    done_cnt = 0;
    fetch(32'hC0);
    wait_dones(2);
    rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_req", mc_req, 1'b0);
      step();
    end
    rst_in = 1'b1;
    step();
    done_cnt = 0;
    fetch(32'hC0);
    wait_valid(lat, d, p);
    chk("rst_remiss", done_cnt, 4);
    chk("rst_data", d, 32'hC0DE_00C0);
    done_cnt = 0;
    fetch(32'h40);
    wait_valid(lat, d, p);
    chk("rst_cleared", done_cnt, 4);

    // Bypass region: single word, never installed
    done_cnt = 0; addr_log.delete();
    fetch(32'h0003_0012);
    wait_valid(lat, d, p);
    chk("byp_data", d, 32'hC0DD_0010);
    chk("byp_pc", p, 32'h0003_0012);
    chk("byp_words", done_cnt, 1);
    chk("byp_addr", addr_log[0], 32'h0003_0010);
    done_cnt = 0;
    fetch(32'h0003_0010);
    wait_valid(lat, d, p);
    chk("byp_again", done_cnt, 1);

    // Rollback during a hit response suppresses it
    fetch(32'hC4);
    rollback = 1'b1;
    @(negedge clk);
    chk("rb_hit_valid", inst_valid, 1'b0);
    step();
    rollback = 1'b0;

    // Rollback in IDLE blocks acceptance
    if_req = 1'b1; if_pc = 32'hC8; rollback = 1'b1;
    @(negedge clk);
    chk("rb_idle_ready", if_ready, 1'b0);
    step();
    if_req = 1'b0; rollback = 1'b0;
    @(negedge clk);
    chk("rb_idle_noresp", inst_valid, 1'b0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
